slot_pick_alloc: RTL and testbench

//  Stateful free-slot allocator. Holds an NSLOT-entry occupancy map and grants up to NPICK

---
 rtl/slot_pick_alloc_if.sv | 33 +++
 rtl/slot_pick_alloc.sv | 134 +++++++++++++
 tb/tb_slot_pick_alloc.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/slot_pick_alloc_if.sv
// Request/grant/release bundle for the slot_pick_alloc free-slot allocator.
// The master side is the session/buffer-descriptor manager and the slave side is the allocator.
// Parameters must match the ones given to the slot_pick_alloc instance.
interface slot_pick_alloc_if #(
    parameter int NSLOT = 16,
    parameter int NPICK = 8,
    parameter int IDXW  = $clog2(NSLOT),
    parameter int CNTW  = $clog2(NPICK + 1),
    parameter int FCW   = $clog2(NSLOT + 1)
);
    logic                  req_valid;
    logic [CNTW-1:0]       req_num;
    logic                  req_ready;
    logic                  grant_valid;
    logic [NPICK*IDXW-1:0] grant_idx;
    logic [CNTW-1:0]       grant_cnt;
    logic                  grant_ready;
    logic                  rel_valid;
    logic [NSLOT-1:0]      rel_mask;
    logic [NSLOT-1:0]      occ_map;
    logic [FCW-1:0]        free_cnt;
    logic                  rel_err;

    modport master (
        output req_valid, req_num, grant_ready, rel_valid, rel_mask,
        input  req_ready, grant_valid, grant_idx, grant_cnt, occ_map, free_cnt, rel_err
    );

    modport slave (
        input  req_valid, req_num, grant_ready, rel_valid, rel_mask,
        output req_ready, grant_valid, grant_idx, grant_cnt, occ_map, free_cnt, rel_err
    );
endinterface

// File: rtl/slot_pick_alloc.sv
// slot_pick_alloc: stateful free-slot allocator.
// Keeps an NSLOT-bit occupancy map and grants up to NPICK free slot indices per request,
// lowest index first, through a single registered grant stage. Slots come back via rel_mask.
// Optional feature macro: SLOT_PICK_ATOMIC_EN (all-or-nothing allocation; a request stalls
// until the registered free count covers the clamped request size).
module slot_pick_alloc #(
    parameter int NSLOT = 16,
    parameter int NPICK = 8
) (
    input  logic             axis_aclk,
    input  logic             axis_rstn,
    slot_pick_alloc_if.slave bus
);
    localparam int IDXW = $clog2(NSLOT);
    localparam int CNTW = $clog2(NPICK + 1);
    localparam int FCW  = $clog2(NSLOT + 1);

    logic [NSLOT-1:0]      occ_q;
    logic [FCW-1:0]        free_q;
    logic                  gnt_valid_q;
    logic [NPICK*IDXW-1:0] gnt_idx_q;
    logic [CNTW-1:0]       gnt_cnt_q;
    logic                  rel_err_q;

    logic                  out_free;
    logic                  ready;
    logic                  accept;
    logic [CNTW-1:0]       req_clamp;
    logic [CNTW-1:0]       pick_n;
    logic [NPICK*IDXW-1:0] pick_idx;
    logic [NSLOT-1:0]      pick_mask;
    logic [NSLOT-1:0]      rel_eff;
    logic [NSLOT-1:0]      occ_next;
    logic [FCW-1:0]        free_next;
    logic                  rel_hit_free;

    // The grant buffer can take a new entry when empty or being drained this cycle.
    assign out_free = !gnt_valid_q || bus.grant_ready;

`ifdef SLOT_PICK_ATOMIC_EN
    // All-or-nothing: hold off the requester until enough slots are free.
    assign ready = out_free && (int'(free_q) >= int'(req_clamp));
`else
    assign ready = out_free;
`endif

    assign accept = bus.req_valid && ready;

    // Clamp the request to NPICK and then to the slots actually available.
    always_comb begin
        req_clamp = bus.req_num;
        if (int'(bus.req_num) > NPICK) begin
            req_clamp = CNTW'(NPICK);
        end
        pick_n = req_clamp;
        if (int'(free_q) < int'(req_clamp)) begin
            pick_n = CNTW'(free_q);
        end
    end

    // NPICK-stage lowest-set-bit peel over the free map; each stage removes the bit it found.
    always_comb begin
        logic [NSLOT-1:0] m;
        logic [IDXW-1:0]  low;
        m         = ~occ_q;
        low       = '0;
        pick_idx  = '0;
        pick_mask = '0;
        for (int k = 0; k < NPICK; k++) begin
            low = '0;
            for (int i = NSLOT - 1; i >= 0; i--) begin
                if (m[i]) begin
                    low = IDXW'(i);
                end
            end
            if ((k < int'(pick_n)) && (m != '0)) begin
                pick_idx[k*IDXW +: IDXW] = low;
                pick_mask[low]           = 1'b1;
            end
            m = m & (m - NSLOT'(1));
        end
    end

    // Next occupancy: releases clear, fresh allocations set and win on overlap.
    always_comb begin
        rel_eff      = bus.rel_valid ? bus.rel_mask : '0;
        occ_next     = (occ_q & ~rel_eff) | (accept ? pick_mask : '0);
        rel_hit_free = |(rel_eff & ~occ_q);
        free_next    = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (!occ_next[i]) begin
                free_next = free_next + FCW'(1);
            end
        end
    end

    // Occupancy map, its free count and the sticky bad-release flag.
    always_ff @(posedge axis_aclk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            occ_q     <= '0;
            free_q    <= FCW'(NSLOT);
            rel_err_q <= 1'b0;
        end else begin
            occ_q  <= occ_next;
            free_q <= free_next;
            if (rel_hit_free) begin
                rel_err_q <= 1'b1;
            end
        end
    end

    // Grant output buffer: load on accept, otherwise drop once the consumer takes it.
    always_ff @(posedge axis_aclk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            gnt_cnt_q   <= '0;
        end else if (accept) begin
            gnt_valid_q <= 1'b1;
            gnt_idx_q   <= pick_idx;
            gnt_cnt_q   <= pick_n;
        end else if (bus.grant_ready) begin
            gnt_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.grant_valid = gnt_valid_q;
    assign bus.grant_idx   = gnt_idx_q;
    assign bus.grant_cnt   = gnt_cnt_q;
    assign bus.occ_map     = occ_q;
    assign bus.free_cnt    = free_q;
    assign bus.rel_err     = rel_err_q;
endmodule

// File: tb/tb_slot_pick_alloc.sv
// Directed testbench for slot_pick_alloc (NSLOT=16, NPICK=8) with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_slot_pick_alloc;
    localparam int NSLOT = 16;
    localparam int NPICK = 8;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    slot_pick_alloc_if #(.NSLOT(NSLOT), .NPICK(NPICK)) bus ();

    slot_pick_alloc #(.NSLOT(NSLOT), .NPICK(NPICK)) dut (
        .axis_aclk (clk),
        .axis_rstn (rstn),
        .bus       (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge happen, return at the next falling edge.
    task automatic applyStimulus(input logic rv, input logic [3:0] rn, input logic gr,
                                 input logic relv, input logic [15:0] relm);
        bus.req_valid   = rv;
        bus.req_num     = rn;
        bus.grant_ready = gr;
        bus.rel_valid   = relv;
        bus.rel_mask    = relm;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkGrant(input string tag, input logic gv, input logic [3:0] cnt,
                              input logic [31:0] idx, input logic [15:0] occ, input logic [4:0] fc);
        checkOutput({tag, ".gv"}, 64'(bus.grant_valid), 64'(gv));
        checkOutput({tag, ".cnt"}, 64'(bus.grant_cnt), 64'(cnt));
        checkOutput({tag, ".idx"}, 64'(bus.grant_idx), 64'(idx));
        checkOutput({tag, ".occ"}, 64'(bus.occ_map), 64'(occ));
        checkOutput({tag, ".free"}, 64'(bus.free_cnt), 64'(fc));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".occ"}, 64'(bus.occ_map), 64'h0);
        checkOutput({tag, ".free"}, 64'(bus.free_cnt), 64'd16);
        checkOutput({tag, ".gv"}, 64'(bus.grant_valid), 64'h0);
        checkOutput({tag, ".idx"}, 64'(bus.grant_idx), 64'h0);
        checkOutput({tag, ".cnt"}, 64'(bus.grant_cnt), 64'h0);
        checkOutput({tag, ".err"}, 64'(bus.rel_err), 64'h0);
    endtask

    // Main directed sequence.
    initial begin
        checks          = 0;
        failures        = 0;
        rstn            = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_num     = '0;
        bus.grant_ready = 1'b0;
        bus.rel_valid   = 1'b0;
        bus.rel_mask    = '0;
        @(negedge clk);
        @(negedge clk);
        checkReset("reset");
        checkOutput("reset.rdy", 64'(bus.req_ready), 64'h1);
        rstn = 1'b1;
        @(negedge clk);

        // T1: three slots from an empty map, grant held (grant_ready low)
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 16'h0000);
        checkGrant("t1", 1'b1, 4'd3, 32'h0000_0210, 16'h0007, 5'd13);
        checkOutput("t1.rdy", 64'(bus.req_ready), 64'h0);

        // T4: request pending while grant_ready stays low for four cycles
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 16'h0000);
            checkOutput("t4.idx", 64'(bus.grant_idx), 64'h0000_0210);
            checkOutput("t4.cnt", 64'(bus.grant_cnt), 64'd3);
            checkOutput("t4.occ", 64'(bus.occ_map), 64'h0007);
            checkOutput("t4.rdy", 64'(bus.req_ready), 64'h0);
        end

        // Back-to-back accepts draining the grant each cycle
        applyStimulus(1'b1, 4'd1, 1'b1, 1'b0, 16'h0000);
        checkGrant("b2b1", 1'b1, 4'd1, 32'h0000_0003, 16'h000F, 5'd12);
        applyStimulus(1'b1, 4'd8, 1'b1, 1'b0, 16'h0000);
        checkGrant("b2b2", 1'b1, 4'd8, 32'hBA98_7654, 16'h0FFF, 5'd4);
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b0, 16'h0000);
        checkGrant("b2b3", 1'b1, 4'd4, 32'h0000_FEDC, 16'hFFFF, 5'd0);

        // Free the low four slots, grant consumed with no new accept
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 16'h000F);
        checkOutput("rel4.gv", 64'(bus.grant_valid), 64'h0);
        checkOutput("rel4.occ", 64'(bus.occ_map), 64'hFFF0);
        checkOutput("rel4.free", 64'(bus.free_cnt), 64'd4);

        // T2: ask for eight with only four free
`ifdef SLOT_PICK_ATOMIC_EN
        applyStimulus(1'b1, 4'd8, 1'b1, 1'b0, 16'h0000);
        checkOutput("t2.stall.gv", 64'(bus.grant_valid), 64'h0);
        checkOutput("t2.stall.occ", 64'(bus.occ_map), 64'hFFF0);
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b0, 16'h0000);
        checkGrant("t2", 1'b1, 4'd4, 32'h0000_3210, 16'hFFFF, 5'd0);
`else
        applyStimulus(1'b1, 4'd8, 1'b1, 1'b0, 16'h0000);
        checkGrant("t2", 1'b1, 4'd4, 32'h0000_3210, 16'hFFFF, 5'd0);
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 16'h0000);
        checkGrant("full", 1'b1, 4'd0, 32'h0000_0000, 16'hFFFF, 5'd0);
`endif

        // Return the upper byte of slots
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 16'hFF00);
        checkOutput("relhi.gv", 64'(bus.grant_valid), 64'h0);
        checkOutput("relhi.occ", 64'(bus.occ_map), 64'h00FF);

        // T3: release and request in the same cycle; freed slots not yet visible
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b1, 16'h0005);
        checkGrant("t3", 1'b1, 4'd2, 32'h0000_0098, 16'h03FA, 5'd8);
        applyStimulus(1'b1, 4'd1, 1'b1, 1'b0, 16'h0000);
        checkGrant("t3next", 1'b1, 4'd1, 32'h0000_0000, 16'h03FB, 5'd7);

        // Release everything, then an oversized request is clamped to eight
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 16'h03FB);
        checkOutput("relall.occ", 64'(bus.occ_map), 64'h0000);
        checkOutput("relall.err", 64'(bus.rel_err), 64'h0);
        applyStimulus(1'b1, 4'd15, 1'b1, 1'b0, 16'h0000);
        checkGrant("clamp", 1'b1, 4'd8, 32'h7654_3210, 16'h00FF, 5'd8);

        // Zero-slot request still produces an empty grant
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 16'h0000);
        checkGrant("zero", 1'b1, 4'd0, 32'h0000_0000, 16'h00FF, 5'd8);

        // T5: releasing an already free slot sets the sticky error
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 16'h8000);
        checkOutput("t5.err", 64'(bus.rel_err), 64'h1);
        checkOutput("t5.occ", 64'(bus.occ_map), 64'h00FF);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 16'h0001);
        checkOutput("t5.sticky", 64'(bus.rel_err), 64'h1);
        checkOutput("t5.occ2", 64'(bus.occ_map), 64'h00FE);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 16'h0000);
        checkGrant("t6pre", 1'b1, 4'd1, 32'h0000_0000, 16'h00FF, 5'd8);

        // T6: asynchronous reset while a grant is pending
        bus.req_valid   = 1'b0;
        bus.grant_ready = 1'b0;
        rstn            = 1'b0;
        #1;
        checkReset("t6");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 16'h0000);
        checkGrant("t6post", 1'b1, 4'd2, 32'h0000_0010, 16'h0003, 5'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
